pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the multicycle CPU core. It consumes the next-PC value produced by the core's next-PC selection logic and drives the instruction-memory request port. It also returns the fetched instruction to the decoder and feeds `pc_plus4` back as the sequential next-PC candidate. All outputs are Moore outputs (decoded from registered state), so there is no combinational path from any input to any output except `pc_plus4` from `pc`.

---
 rtl/pc_fetch_unit.sv | 81 ++++++++
 tb/tb_pc_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction-fetch sequencer
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              commit,
    output logic              misalign,
    output logic [31:0]       retired_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic              r_misalign;
    logic [31:0]       r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        r_instr <= imem_resp_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Low address bits are dropped from pc but remembered in the sticky flag.
                    if (commit) begin
                        r_pc    <= {next_pc[ADDR_W-1:2], 2'b00};
                        r_count <= r_count + 32'd1;
                        if (next_pc[1:0] != 2'b00) begin
                            r_misalign <= 1'b1;
                        end
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign instr_valid    = (r_state == S_EXEC);
    assign instr          = r_instr;
    assign pc             = r_pc;
    assign pc_plus4       = r_pc + ADDR_W'(4);
    assign misalign       = r_misalign;
    assign retired_count  = r_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        commit;
    logic        misalign;
    logic [31:0] retired_count;

    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_a;
    logic [31:0] exp_i;
    logic [31:0] obs_addr;
    logic        obs_stable;
    logic [31:0] obs_instr;
    logic        obs_ivalid;
    int          obs_tvalid;

    pc_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0000_0020)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .next_pc        (next_pc),
        .commit         (commit),
        .misalign       (misalign),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    // One full instruction: stalls, response, optional hold in EXEC, then commit of nxt.
    task automatic run_instr(input int rdy_wait, input int resp_wait, input int exec_wait,
                             input logic [31:0] data, input logic [31:0] nxt);
        logic [31:0] a0;
        a0         = imem_req_addr;
        obs_stable = imem_req_valid;
        for (int i = 0; i < rdy_wait; i++) begin
            imem_req_ready = 1'b0;
            tick();
            if (imem_req_addr !== a0 || imem_req_valid !== 1'b1) obs_stable = 1'b0;
        end
        imem_req_ready = 1'b1;
        obs_addr       = imem_req_addr;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < resp_wait; i++) begin
            imem_resp_valid = 1'b0;
            tick();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        tick();
        imem_resp_valid = 1'b0;
        obs_instr  = instr;
        obs_ivalid = instr_valid;
        obs_tvalid = cyc;
        for (int i = 0; i < exec_wait; i++) begin
            tick();
            if (instr !== data || instr_valid !== 1'b1) obs_ivalid = 1'b0;
        end
        commit  = 1'b1;
        next_pc = nxt;
        tick();
        commit  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20 || instr_valid !== 1'b0 ||
            retired_count !== 32'd0 || misalign !== 1'b0 || instr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hold: rv=%b addr=%h iv=%b cnt=%0d mis=%b instr=%h, required rv=1 addr=20 iv=0 cnt=0 mis=0 instr=0",
                     imem_req_valid, imem_req_addr, instr_valid, retired_count, misalign, instr);
        end
        rst_n = 1'b1;
        tick();
        cyc = 0;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20 || instr_valid !== 1'b0 ||
            retired_count !== 32'd0 || pc_plus4 !== 32'h24) begin
            n_fail++;
            $display("FAIL reset_release: rv=%b addr=%h iv=%b cnt=%0d p4=%h, required 1 20 0 0 24",
                     imem_req_valid, imem_req_addr, instr_valid, retired_count, pc_plus4);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] mpc;
        mpc = 32'h20;
        for (int k = 0; k < 3; k++) begin
            exp_addr_q.push_back(mpc);
            exp_instr_q.push_back(32'h13);
            n_checks++;
            if (pc_plus4 !== mpc + 32'd4) begin
                n_fail++;
                $display("FAIL seq_pc_plus4[%0d]: got %h required %h", k, pc_plus4, mpc + 32'd4);
            end
            run_instr(0, 0, 0, 32'h13, mpc + 32'd4);
            exp_a = exp_addr_q.pop_front();
            exp_i = exp_instr_q.pop_front();
            n_checks++;
            if (obs_addr !== exp_a || obs_instr !== exp_i || obs_ivalid !== 1'b1 || obs_tvalid != 2 + 3 * k) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: addr=%h instr=%h iv=%b cyc=%0d, required %h %h 1 %0d",
                         k, obs_addr, obs_instr, obs_ivalid, obs_tvalid, exp_a, exp_i, 2 + 3 * k);
            end
            mpc = mpc + 32'd4;
        end
        n_checks++;
        if (imem_req_addr !== 32'h2C || retired_count !== 32'd3 || imem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_end: addr=%h cnt=%0d rv=%b, required 2c 3 1", imem_req_addr, retired_count, imem_req_valid);
        end
    endtask

    task automatic test_jump_stall();
        exp_addr_q.push_back(32'h2C);
        exp_instr_q.push_back(32'hA5A5_0001);
        run_instr(4, 3, 2, 32'hA5A5_0001, 32'h58);
        exp_a = exp_addr_q.pop_front();
        exp_i = exp_instr_q.pop_front();
        n_checks++;
        if (obs_addr !== exp_a || obs_stable !== 1'b1 || obs_instr !== exp_i || obs_ivalid !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_stall_fetch: addr=%h stable=%b instr=%h iv=%b, required %h 1 %h 1",
                     obs_addr, obs_stable, obs_instr, obs_ivalid, exp_a, exp_i);
        end
        n_checks++;
        if (imem_req_addr !== 32'h58 || misalign !== 1'b0 || retired_count !== 32'd4) begin
            n_fail++;
            $display("FAIL jump_target: addr=%h mis=%b cnt=%0d, required 58 0 4", imem_req_addr, misalign, retired_count);
        end
    endtask

    task automatic test_misalign();
        exp_addr_q.push_back(32'h58);
        run_instr(0, 1, 0, 32'h0000_0001, 32'h4B);
        exp_a = exp_addr_q.pop_front();
        n_checks++;
        if (obs_addr !== exp_a || pc !== 32'h48 || misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_set: addr=%h pc=%h mis=%b, required %h 48 1", obs_addr, pc, misalign, exp_a);
        end
        exp_addr_q.push_back(32'h48);
        run_instr(1, 0, 0, 32'h0000_0002, 32'h4C);
        exp_a = exp_addr_q.pop_front();
        n_checks++;
        if (obs_addr !== exp_a || pc !== 32'h4C || misalign !== 1'b1 || retired_count !== 32'd6) begin
            n_fail++;
            $display("FAIL misalign_sticky: addr=%h pc=%h mis=%b cnt=%0d, required %h 4c 1 6",
                     obs_addr, pc, misalign, retired_count, exp_a);
        end
    endtask

    task automatic test_spurious();
        logic [31:0] prev_instr;
        prev_instr      = instr;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        commit          = 1'b1;
        next_pc         = 32'h100;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || instr !== prev_instr || pc !== 32'h4C || retired_count !== 32'd6) begin
            n_fail++;
            $display("FAIL spurious_in_req: rv=%b instr=%h pc=%h cnt=%0d, required 1 %h 4c 6",
                     imem_req_valid, instr, pc, retired_count, prev_instr);
        end
        // Response coinciding with the handshake must not be taken.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        tick();
        commit = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== prev_instr ||
            pc !== 32'h4C || retired_count !== 32'd6) begin
            n_fail++;
            $display("FAIL spurious_in_wait: rv=%b iv=%b instr=%h pc=%h cnt=%0d, required 0 0 %h 4c 6",
                     imem_req_valid, instr_valid, instr, pc, retired_count, prev_instr);
        end
        exp_instr_q.push_back(32'h0000_00EF);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_00EF;
        tick();
        imem_resp_valid = 1'b0;
        exp_i = exp_instr_q.pop_front();
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== exp_i) begin
            n_fail++;
            $display("FAIL spurious_recover: iv=%b instr=%h, required 1 %h", instr_valid, instr, exp_i);
        end
        commit  = 1'b1;
        next_pc = 32'hFFFF_FFFC;
        tick();
        commit = 1'b0;
    endtask

    task automatic test_wrap();
        n_checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || retired_count !== 32'd7) begin
            n_fail++;
            $display("FAIL wrap_pc_plus4: pc=%h p4=%h cnt=%0d, required fffffffc 0 7", pc, pc_plus4, retired_count);
        end
        exp_addr_q.push_back(32'hFFFF_FFFC);
        run_instr(0, 0, 0, 32'h0000_0013, 32'h0);
        exp_a = exp_addr_q.pop_front();
        n_checks++;
        if (obs_addr !== exp_a || imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_fetch: prev=%h next=%h rv=%b, required %h 0 1", obs_addr, imem_req_addr, imem_req_valid, exp_a);
        end
    endtask

    task automatic test_mid_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        tick();
        imem_resp_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (pc !== 32'h20 || instr_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
            retired_count !== 32'd0 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: pc=%h iv=%b rv=%b cnt=%0d mis=%b, required 20 0 1 0 0",
                     pc, instr_valid, imem_req_valid, retired_count, misalign);
        end
        tick();
        rst_n           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h20) begin
            n_fail++;
            $display("FAIL mid_reset_late_resp: rv=%b iv=%b instr=%h pc=%h, required 1 0 0 20",
                     imem_req_valid, instr_valid, instr, pc);
        end
        exp_addr_q.push_back(32'h20);
        exp_instr_q.push_back(32'h0000_0033);
        run_instr(0, 0, 0, 32'h0000_0033, 32'h24);
        exp_a = exp_addr_q.pop_front();
        exp_i = exp_instr_q.pop_front();
        n_checks++;
        if (obs_addr !== exp_a || obs_instr !== exp_i || retired_count !== 32'd1 || pc !== 32'h24) begin
            n_fail++;
            $display("FAIL mid_reset_refetch: addr=%h instr=%h cnt=%0d pc=%h, required %h %h 1 24",
                     obs_addr, obs_instr, retired_count, pc, exp_a, exp_i);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        cyc             = 0;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        next_pc         = '0;
        commit          = 1'b0;
        test_reset();
        test_sequential();
        test_jump_stall();
        test_misalign();
        test_spurious();
        test_wrap();
        test_mid_reset();
        n_checks++;
        if (exp_addr_q.size() != 0 || exp_instr_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: addr_q=%0d instr_q=%0d, required 0 0", exp_addr_q.size(), exp_instr_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
